// File: rtl/banked_glb.sv
// banked_glb: LANES-bank global buffer with a wide row port (A) and a
// narrow word port (B). Registered reads, read-first on every conflict,
// B-write drop with collision counting, and out-of-range row detection.
// Optional psum read-modify-write on port B is built when GLB_ACCUM_EN is defined.
module banked_glb #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR       = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we_a,
  input  logic                          re_a,
  input  logic [ADDR-1:0]               addr_a,
  input  logic [LANES*DATA_WIDTH-1:0]   wdata_a,
  output logic [LANES*DATA_WIDTH-1:0]   rdata_a,
  output logic                          rvalid_a,
  input  logic                          we_b,
  input  logic                          re_b,
  input  logic                          acc_b,
  input  logic [ADDR-1:0]               addr_b,
  input  logic [DATA_WIDTH-1:0]         wdata_b,
  output logic [DATA_WIDTH-1:0]         rdata_b,
  output logic                          rvalid_b,
  output logic                          ready_b,
  output logic                          collision,
  output logic [15:0]                   coll_count,
  output logic                          addr_err
);

  localparam int LB   = $clog2(LANES);
  localparam int ROWS = DEPTH / LANES;
  localparam int RW   = ADDR - LB;
  localparam logic [RW:0] ROWS_W = ROWS[RW:0];

  logic [RW-1:0] row_a, row_b;
  logic [LB-1:0] lane_b;
  logic          row_a_ok, row_b_ok, a_wr, same_row_ab;
  logic          b_plain_we, b_rd, acc_start, acc_coll, coll_plain;
  logic          b_wr_en;
  logic [RW-1:0] b_wr_row;
  logic [LB-1:0] b_wr_lane;
  logic [DATA_WIDTH-1:0] b_wr_data;
  logic [LANES*DATA_WIDTH-1:0] rd_a_all;
  logic [DATA_WIDTH-1:0] bank_b_arr [LANES];

  assign row_a       = addr_a[ADDR-1:LB];
  assign row_b       = addr_b[ADDR-1:LB];
  assign lane_b      = addr_b[LB-1:0];
  assign row_a_ok    = ({1'b0, row_a} < ROWS_W);
  assign row_b_ok    = ({1'b0, row_b} < ROWS_W);
  assign a_wr        = we_a & row_a_ok;
  assign same_row_ab = (row_a == row_b);
  assign coll_plain  = b_plain_we & row_b_ok & a_wr & same_row_ab;
  // Accumulate start also reads the word, so the old value lands in the bank register.
  assign b_rd        = ((re_b & ready_b) | acc_start) & row_b_ok;

`ifdef GLB_ACCUM_EN
  logic                  acc_pend_q, acc_pend_d;
  logic [RW-1:0]         acc_row_q, acc_row_d;
  logic [LB-1:0]         acc_lane_q, acc_lane_d;
  logic [DATA_WIDTH-1:0] acc_add_q, acc_add_d;
  logic [DATA_WIDTH:0]   acc_sum;
  logic [DATA_WIDTH-1:0] acc_sat;
  logic                  unused_acc;

  // ready_b drops during the write cycle, so a following accumulate to the
  // same word always reads memory after the previous sum has been committed.
  assign ready_b    = ~acc_pend_q;
  assign acc_start  = we_b & acc_b & ready_b;
  assign b_plain_we = we_b & ~acc_b & ready_b;
  assign acc_coll   = acc_pend_q & a_wr & (row_a == acc_row_q);
  assign unused_acc = 1'b0;

  // Signed saturating add of the old word and the captured addend.
  always_comb begin
    acc_sum = {bank_b_arr[acc_lane_q][DATA_WIDTH-1], bank_b_arr[acc_lane_q]}
            + {acc_add_q[DATA_WIDTH-1], acc_add_q};
    acc_sat = acc_sum[DATA_WIDTH-1:0];
    if (acc_sum[DATA_WIDTH] != acc_sum[DATA_WIDTH-1])
      acc_sat = acc_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  // Capture the accumulate target and addend in the read cycle.
  always_comb begin
    acc_pend_d = acc_start & row_b_ok;
    acc_row_d  = acc_row_q;
    acc_lane_d = acc_lane_q;
    acc_add_d  = acc_add_q;
    if (acc_start) begin
      acc_row_d  = row_b;
      acc_lane_d = lane_b;
      acc_add_d  = wdata_b;
    end
  end

  // Accumulate pipeline register; reset discards a pending sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_pend_q <= 1'b0;
      acc_row_q  <= '0;
      acc_lane_q <= '0;
      acc_add_q  <= '0;
    end else begin
      acc_pend_q <= acc_pend_d;
      acc_row_q  <= acc_row_d;
      acc_lane_q <= acc_lane_d;
      acc_add_q  <= acc_add_d;
    end
  end
`else
  logic unused_acc;
  assign ready_b    = 1'b1;
  assign acc_start  = 1'b0;
  assign acc_coll   = 1'b0;
  assign b_plain_we = we_b;
  assign unused_acc = acc_b;
`endif

  logic unused_addr;
  assign unused_addr = ^{addr_a[LB-1:0], unused_acc};

  // Port B write source: plain write unless an accumulate sum is due.
  always_comb begin
    b_wr_en   = b_plain_we & row_b_ok & ~(a_wr & same_row_ab);
    b_wr_row  = row_b;
    b_wr_lane = lane_b;
    b_wr_data = wdata_b;
`ifdef GLB_ACCUM_EN
    if (acc_pend_q && !acc_coll && !reset) begin
      b_wr_en   = 1'b1;
      b_wr_row  = acc_row_q;
      b_wr_lane = acc_lane_q;
      b_wr_data = acc_sat;
    end
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [ROWS];
      logic [DATA_WIDTH-1:0] bank_a_q, bank_b_q;

      // Dual-port bank: two writes, two registered reads, read-first.
      always_ff @(posedge clk) begin
        if (a_wr)
          mem[row_a] <= wdata_a[gi*DATA_WIDTH +: DATA_WIDTH];
        if (b_wr_en && b_wr_lane == LB'(gi))
          mem[b_wr_row] <= b_wr_data;
        if (reset) begin
          bank_a_q <= '0;
          bank_b_q <= '0;
        end else begin
          if (re_a && row_a_ok)
            bank_a_q <= mem[row_a];
          if (b_rd && lane_b == LB'(gi))
            bank_b_q <= mem[row_b];
        end
      end

      assign rd_a_all[gi*DATA_WIDTH +: DATA_WIDTH] = bank_a_q;
      assign bank_b_arr[gi] = bank_b_q;
    end
  endgenerate

  logic                  rvalid_a_q, rvalid_a_d, rerr_a_q, rerr_a_d;
  logic                  rvalid_b_q, rvalid_b_d, rerr_b_q, rerr_b_d;
  logic [LB-1:0]         lane_q, lane_d;
  logic [DATA_WIDTH-1:0] hold_b_q, hold_b_d;
  logic                  coll_q, coll_d, addr_err_q, addr_err_d;
  logic [15:0]           coll_cnt_q, coll_cnt_d;

  // Read strobes, output lane select, collision and range-error bookkeeping.
  always_comb begin
    rvalid_a_d = re_a;
    rerr_a_d   = re_a ? ~row_a_ok : rerr_a_q;
    rvalid_b_d = re_b & ready_b;
    rerr_b_d   = rvalid_b_d ? ~row_b_ok : rerr_b_q;
    lane_d     = rvalid_b_d ? lane_b : lane_q;
    hold_b_d   = rdata_b;
    coll_d     = coll_plain | acc_coll;
    coll_cnt_d = coll_cnt_q;
    if (coll_d && coll_cnt_q != 16'hFFFF)
      coll_cnt_d = coll_cnt_q + 16'd1;
    addr_err_d = ((we_a | re_a) & ~row_a_ok) | (ready_b & (we_b | re_b) & ~row_b_ok);
  end

  // Control registers; reset drops pending read strobes and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_a_q <= 1'b0;
      rerr_a_q   <= 1'b0;
      rvalid_b_q <= 1'b0;
      rerr_b_q   <= 1'b0;
      lane_q     <= '0;
      hold_b_q   <= '0;
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rvalid_a_q <= rvalid_a_d;
      rerr_a_q   <= rerr_a_d;
      rvalid_b_q <= rvalid_b_d;
      rerr_b_q   <= rerr_b_d;
      lane_q     <= lane_d;
      hold_b_q   <= hold_b_d;
      coll_q     <= coll_d;
      coll_cnt_q <= coll_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Port B output follows a fresh read, otherwise holds the last returned word
  // so accumulate reads through the bank register stay invisible.
  assign rdata_b    = rvalid_b_q ? (rerr_b_q ? '0 : bank_b_arr[lane_q]) : hold_b_q;
  assign rdata_a    = rerr_a_q ? '0 : rd_a_all;
  assign rvalid_a   = rvalid_a_q;
  assign rvalid_b   = rvalid_b_q;
  assign collision  = coll_q;
  assign coll_count = coll_cnt_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_banked_glb.sv
// Scoreboard bench for banked_glb (LANES=4, DATA_WIDTH=16, DEPTH=60 so rows 0..14 exist).
module tb_banked_glb;
  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, re_a, we_b, re_b, acc_b;
  logic [5:0]  addr_a, addr_b;
  logic [63:0] wdata_a, rdata_a;
  logic [15:0] wdata_b, rdata_b, coll_count;
  logic        rvalid_a, rvalid_b, ready_b, collision, addr_err;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] q_a [$];
  logic [15:0] q_b [$];
  logic        tb_rdy = 1'b1;

  banked_glb #(.LANES(4), .DATA_WIDTH(16), .DEPTH(60)) u_dut (
    .clk(clk), .reset(reset),
    .we_a(we_a), .re_a(re_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .we_b(we_b), .re_b(re_b), .acc_b(acc_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .rvalid_b(rvalid_b), .ready_b(ready_b),
    .collision(collision), .coll_count(coll_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic idle_inputs();
    we_a = 0; re_a = 0; addr_a = '0; wdata_a = '0;
    we_b = 0; re_b = 0; acc_b = 0; addr_b = '0; wdata_b = '0;
  endtask

  // One clock of stimulus; expected read data goes into the scoreboard queues.
  task automatic cyc(input logic wa, input logic ra, input logic [5:0] aa, input logic [63:0] wda,
                     input logic wb, input logic rb, input logic ac, input logic [5:0] ab,
                     input logic [15:0] wdb, input logic [63:0] exp_a, input logic [15:0] exp_b,
                     input logic e_coll, input logic e_err);
    logic iss_a, iss_b, rdy_next;
    logic [63:0] ea;
    logic [15:0] eb;
    we_a = wa; re_a = ra; addr_a = aa; wdata_a = wda;
    we_b = wb; re_b = rb; acc_b = ac; addr_b = ab; wdata_b = wdb;
    iss_a = ra;
    iss_b = rb && tb_rdy;
    if (iss_a) q_a.push_back(exp_a);
    if (iss_b) q_b.push_back(exp_b);
`ifdef GLB_ACCUM_EN
    rdy_next = !(wb && ac && tb_rdy);
`else
    rdy_next = 1'b1;
`endif
    @(posedge clk);
    #1;
    idle_inputs();
    check("rvalid_a", {63'd0, rvalid_a}, {63'd0, iss_a});
    if (iss_a && q_a.size() > 0) begin
      ea = q_a.pop_front();
      check("rdata_a", rdata_a, ea);
    end
    check("rvalid_b", {63'd0, rvalid_b}, {63'd0, iss_b});
    if (iss_b && q_b.size() > 0) begin
      eb = q_b.pop_front();
      check("rdata_b", {48'd0, rdata_b}, {48'd0, eb});
    end
    check("collision", {63'd0, collision}, {63'd0, e_coll});
    check("addr_err", {63'd0, addr_err}, {63'd0, e_err});
    tb_rdy = rdy_next;
    check("ready_b", {63'd0, ready_b}, {63'd0, tb_rdy});
  endtask

  task automatic nop();
    cyc(0, 0, 6'd0, 64'd0, 0, 0, 0, 6'd0, 16'd0, 64'd0, 16'd0, 0, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rdata_a", rdata_a, 64'd0);
    check("rst_rdata_b", {48'd0, rdata_b}, 64'd0);
    check("rst_rvalid", {62'd0, rvalid_a, rvalid_b}, 64'd0);
    check("rst_coll_count", {48'd0, coll_count}, 64'd0);
    check("rst_pulses", {62'd0, collision, addr_err}, 64'd0);
    check("rst_ready_b", {63'd0, ready_b}, 64'd1);

    // Row fill on A, lane reads on B.
    cyc(1, 0, 6'd8, 64'h0004_0003_0002_0001, 0, 0, 0, 6'd0, 16'd0, 64'd0, 16'd0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'(8 + i), 16'd0, 64'd0, 16'(i + 1), 0, 0);
    nop();
    check("hold_rdata_b", {48'd0, rdata_b}, 64'd4);

    // Word write on B, row read on A.
    cyc(1, 0, 6'd12, 64'd0, 0, 0, 0, 6'd0, 16'd0, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 0, 6'd13, 16'hBEEF, 64'd0, 16'd0, 0, 0);
    cyc(0, 1, 6'd12, 64'd0, 0, 0, 0, 6'd0, 16'd0, 64'h0000_0000_BEEF_0000, 16'd0, 0, 0);

    // Same-row A/B write collision: B dropped.
    cyc(1, 0, 6'd4, 64'd0, 1, 0, 0, 6'd5, 16'h1234, 64'd0, 16'd0, 1, 0);
    check("coll_count_1", {48'd0, coll_count}, 64'd1);
    nop();
    check("coll_count_hold", {48'd0, coll_count}, 64'd1);
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd5, 16'd0, 64'd0, 16'h0000, 0, 0);
    // Different rows: both writes land.
    cyc(1, 0, 6'd24, 64'd0, 1, 0, 0, 6'd29, 16'h4242, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd29, 16'd0, 64'd0, 16'h4242, 0, 0);

    // Read-first, cross port and same port.
    cyc(1, 0, 6'd16, 64'h1111_2222_3333_4444, 0, 0, 0, 6'd0, 16'd0, 64'd0, 16'd0, 0, 0);
    cyc(1, 0, 6'd16, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1, 0, 6'd17, 16'd0, 64'd0, 16'h3333, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd17, 16'd0, 64'd0, 16'hCCCC, 0, 0);
    cyc(1, 1, 6'd16, 64'h5555_6666_7777_8888, 0, 0, 0, 6'd0, 16'd0, 64'hAAAA_BBBB_CCCC_DDDD, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 1, 1, 0, 6'd18, 16'h9999, 64'd0, 16'h6666, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd18, 16'd0, 64'd0, 16'h9999, 0, 0);

    // Out-of-range row 15.
    cyc(1, 0, 6'd0, 64'hCAFE_0003_0002_0001, 0, 0, 0, 6'd0, 16'd0, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd61, 16'd0, 64'd0, 16'h0000, 0, 1);
    cyc(1, 0, 6'd60, 64'hDEAD_DEAD_DEAD_DEAD, 0, 0, 0, 6'd0, 16'd0, 64'd0, 16'd0, 0, 1);
    cyc(0, 1, 6'd60, 64'd0, 0, 0, 0, 6'd0, 16'd0, 64'd0, 16'd0, 0, 1);
    cyc(0, 1, 6'd0, 64'd0, 0, 0, 0, 6'd0, 16'd0, 64'hCAFE_0003_0002_0001, 16'd0, 0, 0);

`ifdef GLB_ACCUM_EN
    // Positive saturation.
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 0, 6'd20, 16'h7FF0, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 1, 6'd20, 16'h0020, 64'd0, 16'd0, 0, 0);
    nop();
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd20, 16'd0, 64'd0, 16'h7FFF, 0, 0);
    // Back-to-back +1 on zero; the request while ready_b is low is ignored.
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 0, 6'd21, 16'h0000, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 1, 6'd21, 16'h0001, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 1, 6'd21, 16'h0001, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 1, 6'd21, 16'h0001, 64'd0, 16'd0, 0, 0);
    nop();
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd21, 16'd0, 64'd0, 16'h0002, 0, 0);
    // Negative saturation, then acc_b without we_b does nothing.
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 0, 6'd22, 16'h8000, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 1, 6'd22, 16'hFFFF, 64'd0, 16'd0, 0, 0);
    nop();
    cyc(0, 0, 6'd0, 64'd0, 0, 0, 1, 6'd22, 16'h0005, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd22, 16'd0, 64'd0, 16'h8000, 0, 0);
`else
    // Without the accumulator acc_b is a plain write.
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 0, 6'd22, 16'h0005, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 1, 0, 1, 6'd22, 16'h0003, 64'd0, 16'd0, 0, 0);
    cyc(0, 0, 6'd0, 64'd0, 0, 1, 0, 6'd22, 16'd0, 64'd0, 16'h0003, 0, 0);
`endif

    // Reset arriving with a row read: no rvalid, counters cleared, RAM kept.
    re_a = 1'b1; addr_a = 6'd8; reset = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
    tb_rdy = 1'b1;
    check("rst_mid_rvalid_a", {63'd0, rvalid_a}, 64'd0);
    check("rst_mid_coll_count", {48'd0, coll_count}, 64'd0);
    nop();
    cyc(0, 1, 6'd8, 64'd0, 0, 1, 0, 6'd9, 16'd0, 64'h0004_0003_0002_0001, 16'h0002, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
